// File: rtl/tsp_srf_pkg.sv
// Shared geometry defaults and vector types for the streaming register file.
package tsp_srf_pkg;

    localparam int DEF_NUM_STREAMS  = 32;
    localparam int DEF_NUM_TILES    = 20;
    localparam int DEF_LANE_W       = 16;
    localparam int DEF_NUM_RD_PORTS = 2;
    localparam int DEF_SID_W        = $clog2(DEF_NUM_STREAMS);

    typedef logic [DEF_LANE_W-1:0] lane_t;
    typedef lane_t [DEF_NUM_TILES-1:0] vec_t;
    typedef logic [DEF_SID_W-1:0] sid_t;

endpackage

// File: rtl/streaming_register_file_mp_read_port.sv
// One read port: hit/miss decision with write bypass, and the registered outputs.
module srf_read_port
    import tsp_srf_pkg::*;
#(
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int NUM_TILES   = DEF_NUM_TILES,
    parameter int LANE_W      = DEF_LANE_W,
    parameter int SID_W       = $clog2(NUM_STREAMS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rd_en,
    input  logic [SID_W-1:0]                  rd_sid,
    input  logic [NUM_STREAMS-1:0]            stream_vld,
    input  logic                              wr_ok,
    input  logic [SID_W-1:0]                  wr_sid,
    input  logic [NUM_TILES-1:0][LANE_W-1:0]  wr_data,
    input  logic [NUM_TILES-1:0][LANE_W-1:0]  stored_data,
    output logic                              hit,
    output logic                              rd_valid,
    output logic                              rd_miss,
    output logic [NUM_TILES-1:0][LANE_W-1:0]  rd_data
);

    logic in_range;
    logic bypass;

    assign in_range = int'(rd_sid) < NUM_STREAMS;
    // wr_ok already implies wr_sid is in range, so a matching sid is a real bypass.
    assign bypass   = wr_ok && (wr_sid == rd_sid);
    assign hit      = rd_en && in_range && (stream_vld[rd_sid] || bypass);

    // A miss leaves the data register untouched so consumers see the last hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= hit;
            rd_miss  <= rd_en && !hit;
            if (hit) begin
                rd_data <= bypass ? wr_data : stored_data;
            end
        end
    end

endmodule

// File: rtl/streaming_register_file_mp.sv
// Multi-read-port streaming register file with per-stream valid scoreboard,
// write-to-read bypass, consume-on-read and flush.
module streaming_register_file_mp
    import tsp_srf_pkg::*;
#(
    parameter int  NUM_STREAMS  = DEF_NUM_STREAMS,
    parameter int  NUM_TILES    = DEF_NUM_TILES,
    parameter int  LANE_W       = DEF_LANE_W,
    parameter int  NUM_RD_PORTS = DEF_NUM_RD_PORTS,
    localparam int SID_W        = $clog2(NUM_STREAMS)
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 flush,
    input  logic                                                 wr_en,
    input  logic [SID_W-1:0]                                     wr_sid,
    input  logic [NUM_TILES-1:0][LANE_W-1:0]                     wr_data,
    input  logic [NUM_RD_PORTS-1:0]                              rd_en,
    input  logic [NUM_RD_PORTS-1:0][SID_W-1:0]                   rd_sid,
    input  logic [NUM_RD_PORTS-1:0]                              rd_consume,
    output logic [NUM_RD_PORTS-1:0]                              rd_valid,
    output logic [NUM_RD_PORTS-1:0]                              rd_miss,
    output logic [NUM_RD_PORTS-1:0][NUM_TILES-1:0][LANE_W-1:0]   rd_data,
    output logic [NUM_STREAMS-1:0]                               stream_vld
);

    logic [NUM_TILES-1:0][LANE_W-1:0] mem [NUM_STREAMS];
    logic                             wr_ok;
    logic [NUM_RD_PORTS-1:0]          hit;
    logic [NUM_STREAMS-1:0]           consume_mask;
    logic [NUM_STREAMS-1:0]           vld_next;

    assign wr_ok = wr_en && (int'(wr_sid) < NUM_STREAMS);

    // Contents are never reset; stream_vld decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_sid] <= wr_data;
        end
    end

    always_comb begin
        consume_mask = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (hit[p] && rd_consume[p]) begin
                consume_mask[rd_sid[p]] = 1'b1;
            end
        end
    end

    // Clears are applied first so a same-cycle write always wins.
    always_comb begin
        vld_next = flush ? '0 : stream_vld;
        vld_next = vld_next & ~consume_mask;
        if (wr_ok) begin
            vld_next[wr_sid] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_vld <= '0;
        end else begin
            stream_vld <= vld_next;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        srf_read_port #(
            .NUM_STREAMS (NUM_STREAMS),
            .NUM_TILES   (NUM_TILES),
            .LANE_W      (LANE_W),
            .SID_W       (SID_W)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .rd_en       (rd_en[p]),
            .rd_sid      (rd_sid[p]),
            .stream_vld  (stream_vld),
            .wr_ok       (wr_ok),
            .wr_sid      (wr_sid),
            .wr_data     (wr_data),
            .stored_data (mem[rd_sid[p]]),
            .hit         (hit[p]),
            .rd_valid    (rd_valid[p]),
            .rd_miss     (rd_miss[p]),
            .rd_data     (rd_data[p])
        );
    end

endmodule

// File: tb/tb_streaming_register_file_mp.sv
// Scoreboard bench: directed reads push expected responses, a negedge monitor pops and compares.
module tb_streaming_register_file_mp;
    import tsp_srf_pkg::*;

    localparam int NS = 20;
    localparam int SW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            wr_en;
    logic [SW-1:0]   wr_sid;
    vec_t            wr_data;
    logic [1:0]      rd_en;
    logic [1:0][SW-1:0] rd_sid;
    logic [1:0]      rd_consume;
    logic [1:0]      rd_valid;
    logic [1:0]      rd_miss;
    vec_t [1:0]      rd_data;
    logic [NS-1:0]   stream_vld;

    typedef struct {
        logic          valid;
        logic          miss;
        vec_t          data;
        logic [NS-1:0] vld;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    streaming_register_file_mp #(
        .NUM_STREAMS  (NS),
        .NUM_TILES    (20),
        .LANE_W       (16),
        .NUM_RD_PORTS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_sid     (wr_sid),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_sid     (rd_sid),
        .rd_consume (rd_consume),
        .rd_valid   (rd_valid),
        .rd_miss    (rd_miss),
        .rd_data    (rd_data),
        .stream_vld (stream_vld)
    );

    function automatic vec_t ramp(input lane_t base);
        vec_t v;
        for (int i = 0; i < 20; i++) v[i] = base + 16'(i);
        return v;
    endfunction

    function automatic vec_t fill(input lane_t x);
        vec_t v;
        for (int i = 0; i < 20; i++) v[i] = x;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic we,
                                 input logic [SW-1:0] ws, input vec_t wd,
                                 input logic [1:0] re, input logic [SW-1:0] s0,
                                 input logic [SW-1:0] s1, input logic [1:0] rc);
        @(posedge clk);
        #1;
        rst        = r;
        flush      = f;
        wr_en      = we;
        wr_sid     = ws;
        wr_data    = wd;
        rd_en      = re;
        rd_sid[0]  = s0;
        rd_sid[1]  = s1;
        rd_consume = rc;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b00, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic expectRead(input int p, input logic v, input logic m,
                              input vec_t d, input logic [NS-1:0] vl);
        exp_t e;
        e.valid = v;
        e.miss  = m;
        e.data  = d;
        e.vld   = vl;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every port output (hit or miss) consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (rd_valid[p] === 1'b1 || rd_miss[p] === 1'b1) begin
                if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL port%0d_unexpected: got valid=%b miss=%b, expected no output",
                             p, rd_valid[p], rd_miss[p]);
                end else begin
                    if (p == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    checkOutput($sformatf("port%0d_valid", p), 320'(rd_valid[p]), 320'(e.valid));
                    checkOutput($sformatf("port%0d_miss", p), 320'(rd_miss[p]), 320'(e.miss));
                    checkOutput($sformatf("port%0d_data", p), 320'(rd_data[p]), 320'(e.data));
                    checkOutput($sformatf("port%0d_stream_vld", p), 320'(stream_vld), 320'(e.vld));
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        wr_en      = 1'b0;
        wr_sid     = '0;
        wr_data    = '0;
        rd_en      = '0;
        rd_sid     = '0;
        rd_consume = '0;

        // Read issued during reset must be suppressed
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd3, 5'd0, 2'b00);
        @(negedge clk);
        checkOutput("reset_stream_vld", 320'(stream_vld), 320'(0));
        checkOutput("reset_rd_valid", 320'(rd_valid), 320'(0));
        checkOutput("reset_rd_miss", 320'(rd_miss), 320'(0));
        checkOutput("reset_rd_data", 320'(rd_data), 320'(0));

        // Read after reset misses
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd3, 5'd0, 2'b00);
        expectRead(0, 1'b0, 1'b1, '0, 20'h00000);

        // Write then read
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, ramp(16'h0500), 2'b00, 5'd0, 5'd0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd5, 5'd0, 2'b00);
        expectRead(0, 1'b1, 1'b0, ramp(16'h0500), 20'h00020);

        // Bypass on both ports
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, fill(16'hA5A5), 2'b11, 5'd7, 5'd7, 2'b00);
        expectRead(0, 1'b1, 1'b0, fill(16'hA5A5), 20'h000A0);
        expectRead(1, 1'b1, 1'b0, fill(16'hA5A5), 20'h000A0);

        // Consume on port 0 while port 1 reads the same sid
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, fill(16'h0202), 2'b00, 5'd0, 5'd0, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd2, 5'd2, 2'b01);
        expectRead(0, 1'b1, 1'b0, fill(16'h0202), 20'h000A0);
        expectRead(1, 1'b1, 1'b0, fill(16'h0202), 20'h000A0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd2, 5'd0, 2'b00);
        expectRead(0, 1'b0, 1'b1, fill(16'h0202), 20'h000A0);

        // Flush + write + consume on sid 9; port 1 reads sid 5 pre-flush
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd9, ramp(16'h0900), 2'b00, 5'd0, 5'd0, 2'b00);
        applyStimulus(1'b0, 1'b1, 1'b1, 5'd9, fill(16'h1234), 2'b11, 5'd9, 5'd5, 2'b01);
        expectRead(0, 1'b1, 1'b0, fill(16'h1234), 20'h00200);
        expectRead(1, 1'b1, 1'b0, ramp(16'h0500), 20'h00200);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd9, 5'd5, 2'b00);
        expectRead(0, 1'b1, 1'b0, fill(16'h1234), 20'h00200);
        expectRead(1, 1'b0, 1'b1, ramp(16'h0500), 20'h00200);

        // Out-of-range write and reads
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd25, fill(16'hBEEF), 2'b01, 5'd25, 5'd0, 2'b00);
        expectRead(0, 1'b0, 1'b1, fill(16'h1234), 20'h00200);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd9, 5'd25, 2'b00);
        expectRead(0, 1'b1, 1'b0, fill(16'h1234), 20'h00200);
        expectRead(1, 1'b0, 1'b1, ramp(16'h0500), 20'h00200);

        // Reset mid-stream, then miss, bypass hit, and a read during flush
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, '0, 2'b11, 5'd9, 5'd9, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, '0, 2'b01, 5'd9, 5'd0, 2'b00);
        expectRead(0, 1'b0, 1'b1, '0, 20'h00000);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd4, fill(16'h4444), 2'b10, 5'd0, 5'd4, 2'b00);
        expectRead(1, 1'b1, 1'b0, fill(16'h4444), 20'h00010);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, '0, 2'b01, 5'd4, 5'd0, 2'b00);
        expectRead(0, 1'b1, 1'b0, fill(16'h4444), 20'h00000);

        idle();
        idle();
        idle();
        @(negedge clk);
        checkOutput("port0_drain", 320'(q0.size()), 320'(0));
        checkOutput("port1_drain", 320'(q1.size()), 320'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
